// File: rtl/aes_dec_key_schedule_if.sv
// Key-schedule interface between the AES-128 decryption core and its
// round-key store. The core (master) requests keys by round index.
// The key schedule (slave) answers with the selected round key and
// reports its progress.
interface aes_dec_key_schedule_if #(
    parameter int KEY_W = 128
);
    logic             key_load;
    logic [KEY_W-1:0] cipher_key;
    logic [3:0]       desired_round;
    logic [KEY_W-1:0] key_out;
    logic             key_expansion_done;
    logic             busy;

    modport master (
        output key_load,
        output cipher_key,
        output desired_round,
        input  key_out,
        input  key_expansion_done,
        input  busy
    );

    modport slave (
        input  key_load,
        input  cipher_key,
        input  desired_round,
        output key_out,
        output key_expansion_done,
        output busy
    );
endinterface

// File: rtl/aes_dec_key_schedule.sv
// AES-128 round-key generator and store for the decryption core.
//
// Operation:
//   - A key_load pulse captures cipher_key as rk[0].
//   - One round key is then expanded per clock until rk[10] is written.
//   - After that, key_out serves rk[desired_round] combinationally.
//
// Optional build macro AES_KS_EQINV_EN:
//   - When defined, rounds 1..9 are presented as InvMixColumns(rk[r]).
//     These are the equivalent-inverse-cipher keys.
//   - Rounds 0 and 10 are always presented unchanged.
//
// Reset is asynchronous and active-low on the 'reset' port. Deassertion
// is synchronised outside this block.
module aes_dec_key_schedule #(
    parameter int ROUNDS = 10,
    parameter int KEY_W  = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_dec_key_schedule_if.slave ks
);

    // Only the AES-128 geometry is implemented.
    generate
        if ((ROUNDS != 10) || (KEY_W != 128)) begin : g_cfg_check
            $error("aes_dec_key_schedule supports only ROUNDS=10 and KEY_W=128");
        end
    endgenerate

    localparam logic [3:0] LAST_RND = 4'(ROUNDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       cnt_r;
    logic [KEY_W-1:0] rk_r [0:ROUNDS];
    logic             busy_r;
    logic             done_r;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic [KEY_W-1:0] prev_key_s;
    logic [KEY_W-1:0] next_key_s;
    logic [KEY_W-1:0] key_out_s;
    logic [31:0]      temp_s;
    logic [31:0]      n0_s;
    logic [31:0]      n1_s;
    logic [31:0]      n2_s;
    logic [31:0]      n3_s;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic helpers.
    // The AES polynomial is x^8 + x^4 + x^3 + x + 1.
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        logic [7:0] r;
        if (a[7]) begin
            r = {a[6:0], 1'b0} ^ 8'h1b;
        end else begin
            r = {a[6:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254. The zero input maps to zero, as
    // the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Forward S-box: field inverse followed by the affine transform.
    // Each call site becomes one combinational S-box instance.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

`ifdef AES_KS_EQINV_EN
    // InvMixColumns on one 32-bit column. Byte 0 is the most significant.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_mix_key(input logic [127:0] k);
        return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
                inv_mix_col(k[63:32]),  inv_mix_col(k[31:0])};
    endfunction
`endif

    // Select the previous round key and compute the next one (function f).
    always_comb begin
        prev_key_s = 128'h0;
        if ((cnt_r != 4'd0) && (cnt_r <= LAST_RND)) begin
            prev_key_s = rk_r[cnt_r - 4'd1];
        end else begin
            prev_key_s = 128'h0;
        end
        temp_s     = sub_word({prev_key_s[23:0], prev_key_s[31:24]})
                     ^ {rcon(cnt_r), 24'h000000};
        n0_s       = prev_key_s[127:96] ^ temp_s;
        n1_s       = prev_key_s[95:64]  ^ n0_s;
        n2_s       = prev_key_s[63:32]  ^ n1_s;
        n3_s       = prev_key_s[31:0]   ^ n2_s;
        next_key_s = {n0_s, n1_s, n2_s, n3_s};
    end

    // FSM state register together with the registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state logic. A load in any state (re)starts the expansion.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ks.key_load) begin
                    state_nxt_s = ST_EXPAND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                if (ks.key_load) begin
                    state_nxt_s = ST_EXPAND;
                end else if (cnt_r == LAST_RND) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_EXPAND;
                end
            end
            ST_DONE: begin
                if (ks.key_load) begin
                    state_nxt_s = ST_EXPAND;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode, taken from the next state so the flags change on the
    // same edge as the state.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_EXPAND: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b0;
            end
            ST_DONE: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Key store and round counter. A load captures rk[0]; each EXPAND
    // cycle writes rk[cnt].
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= 4'd0;
            for (int i = 0; i <= ROUNDS; i++) begin
                rk_r[i] <= 128'h0;
            end
        end else if (ks.key_load) begin
            rk_r[0] <= ks.cipher_key;
            cnt_r   <= 4'd1;
        end else if (state_r == ST_EXPAND) begin
            rk_r[cnt_r] <= next_key_s;
            if (cnt_r == LAST_RND) begin
                cnt_r <= 4'd0;
            end else begin
                cnt_r <= cnt_r + 4'd1;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Combinational read port. Zero unless the store is complete and the
    // requested index is a real round.
    always_comb begin
        key_out_s = 128'h0;
        if (done_r && (ks.desired_round <= LAST_RND)) begin
`ifdef AES_KS_EQINV_EN
            if ((ks.desired_round == 4'd0) || (ks.desired_round == LAST_RND)) begin
                key_out_s = rk_r[ks.desired_round];
            end else begin
                key_out_s = inv_mix_key(rk_r[ks.desired_round]);
            end
`else
            key_out_s = rk_r[ks.desired_round];
`endif
        end else begin
            key_out_s = 128'h0;
        end
    end

    assign ks.key_out            = key_out_s;
    assign ks.key_expansion_done = done_r;
    assign ks.busy               = busy_r;

endmodule

// File: tb/tb_aes_dec_key_schedule.sv
// Scoreboard bench for aes_dec_key_schedule.
//
// Structure:
//   - The stimulus pushes the expected {busy, done, key_out} into a queue.
//   - A monitor pops each entry at the falling edge and compares it with
//     the DUT outputs.
//   - The round keys of the FIPS-197 key are captured during the read
//     sweep. They drive a reference AES-128 decryption of the FIPS-197
//     ciphertext.
module tb_aes_dec_key_schedule;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    aes_dec_key_schedule_if #(.KEY_W(128)) ifc ();

    aes_dec_key_schedule #(.ROUNDS(10), .KEY_W(128)) dut (
        .clk   (clk),
        .reset (reset),
        .ks    (ifc)
    );

    typedef struct {
        int           id;
        logic         busy;
        logic         done;
        logic [127:0] key;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    logic         chk_stb;
    int           n_total = 0;
    int           n_pass  = 0;
    logic [127:0] fips_rk [0:10];
    logic [127:0] cap_key [0:10];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] CT        = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT        = 128'h3243f6a8885a308d313198a2e0370734;

    // ---------------- reference GF / AES helpers ----------------
    function automatic logic [7:0] t_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] t_isbox(input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] r;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        r = a;
        // a^254 = inverse (0 stays 0)
        for (int i = 0; i < 253; i++) r = t_mul(r, a);
        return r;
    endfunction

    function automatic logic [31:0] t_imc_col(input logic [31:0] c);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        {a0, a1, a2, a3} = c;
        return {t_mul(a0, 8'h0e) ^ t_mul(a1, 8'h0b) ^ t_mul(a2, 8'h0d) ^ t_mul(a3, 8'h09),
                t_mul(a0, 8'h09) ^ t_mul(a1, 8'h0e) ^ t_mul(a2, 8'h0b) ^ t_mul(a3, 8'h0d),
                t_mul(a0, 8'h0d) ^ t_mul(a1, 8'h09) ^ t_mul(a2, 8'h0e) ^ t_mul(a3, 8'h0b),
                t_mul(a0, 8'h0b) ^ t_mul(a1, 8'h0d) ^ t_mul(a2, 8'h09) ^ t_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] t_imc(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = t_imc_col(s[127-32*c -: 32]);
        return o;
    endfunction

    function automatic logic [127:0] t_isr(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] t_isub(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t_isbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Expected key_out for round r, given the raw expanded key.
    function automatic logic [127:0] exp_for(input int r, input logic [127:0] raw);
`ifdef AES_KS_EQINV_EN
        if ((r >= 1) && (r <= 9)) return t_imc(raw);
        return raw;
`else
        if (r > 10) return 128'h0;
        return raw;
`endif
    endfunction

    // Decrypt with the keys captured from key_out during the sweep.
    function automatic logic [127:0] t_decrypt(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ cap_key[10];
        for (int r = 9; r >= 1; r--) begin
`ifdef AES_KS_EQINV_EN
            s = t_imc(t_isr(t_isub(s))) ^ cap_key[r];
`else
            s = t_imc(t_isub(t_isr(s)) ^ cap_key[r]);
`endif
        end
        return t_isub(t_isr(s)) ^ cap_key[0];
    endfunction

    // ---------------- monitor ----------------
    // Pop one expectation per strobed cycle and compare at the falling edge.
    always @(negedge clk) begin
        if (chk_stb) begin
            n_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_empty: DUT output presented with no expectation queued");
            end else begin
                mon_e = sb_q.pop_front();
                if ((ifc.busy === mon_e.busy) && (ifc.key_expansion_done === mon_e.done) &&
                    (ifc.key_out === mon_e.key)) begin
                    n_pass++;
                end else begin
                    $display("FAIL chk%0d busy/done/key got %b/%b/%h want %b/%b/%h", mon_e.id,
                             ifc.busy, ifc.key_expansion_done, ifc.key_out,
                             mon_e.busy, mon_e.done, mon_e.key);
                end
                if ((mon_e.id >= 0) && (mon_e.id <= 10)) cap_key[mon_e.id] = ifc.key_out;
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cyc(input int id, input logic b, input logic d, input logic [127:0] k);
        exp_t e;
        e.id   = id;
        e.busy = b;
        e.done = d;
        e.key  = k;
        sb_q.push_back(e);
        chk_stb = 1'b1;
        tick();
        chk_stb = 1'b0;
    endtask

    task automatic load_key(input logic [127:0] k);
        ifc.cipher_key = k;
        ifc.key_load   = 1'b1;
        tick();
        ifc.key_load   = 1'b0;
        ifc.cipher_key = ~k;
    endtask

    // Observations j = 0..9 after the load edge must show busy; j = 10 shows done.
    task automatic wait_done_exact(input int id, input int rnd, input logic [127:0] k_exp);
        ifc.desired_round = 4'(rnd);
        for (int j = 0; j < 10; j++) check_cyc(id + j, 1'b1, 1'b0, 128'h0);
        check_cyc(id + 10, 1'b0, 1'b1, k_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] pt;
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset             = 1'b0;
        chk_stb           = 1'b0;
        ifc.key_load      = 1'b0;
        ifc.cipher_key    = 128'h0;
        ifc.desired_round = 4'd0;
        tick();
        check_cyc(20, 1'b0, 1'b0, 128'h0);
        reset = 1'b1;
        check_cyc(21, 1'b0, 1'b0, 128'h0);

        // Reset asserted in the middle of an expansion
        load_key(FIPS_KEY);
        tick();
        tick();
        tick();
        check_cyc(25, 1'b1, 1'b0, 128'h0);
        reset = 1'b0;
        check_cyc(22, 1'b0, 1'b0, 128'h0);
        ifc.desired_round = 4'd10;
        check_cyc(23, 1'b0, 1'b0, 128'h0);
        reset = 1'b1;
        check_cyc(24, 1'b0, 1'b0, 128'h0);

        // FIPS-197 key, then the read sweep 10 down to 0
        load_key(FIPS_KEY);
        wait_done_exact(30, 1, exp_for(1, fips_rk[1]));
        for (int r = 10; r >= 0; r--) begin
            ifc.desired_round = 4'(r);
            check_cyc(r, 1'b0, 1'b1, exp_for(r, fips_rk[r]));
        end
        ifc.desired_round = 4'd11;
        check_cyc(50, 1'b0, 1'b1, 128'h0);
        ifc.desired_round = 4'd15;
        check_cyc(51, 1'b0, 1'b1, 128'h0);
        pt = t_decrypt(CT);
        n_total++;
        if (pt === PT) n_pass++;
        else $display("FAIL decrypt got %h want %h", pt, PT);

        // All-zero key, loaded from DONE
        load_key(128'h0);
        wait_done_exact(60, 10, ZERO_RK10);
        ifc.desired_round = 4'd1;
        check_cyc(71, 1'b0, 1'b1, exp_for(1, ZERO_RK1));

        // Reload at cycle 4 of an expansion
        load_key(FIPS_KEY);
        tick();
        tick();
        tick();
        load_key(128'h0);
        wait_done_exact(80, 10, ZERO_RK10);

        // key_load held for three cycles; the last sample wins
        ifc.key_load   = 1'b1;
        ifc.cipher_key = 128'h0;
        tick();
        tick();
        ifc.cipher_key = FIPS_KEY;
        tick();
        ifc.key_load   = 1'b0;
        ifc.cipher_key = 128'h0;
        wait_done_exact(100, 0, FIPS_KEY);
        ifc.desired_round = 4'd10;
        check_cyc(111, 1'b0, 1'b1, fips_rk[10]);

        n_total++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL sb_drain got %0d left want 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
